// File: rtl/tcdm_master_shim.sv
// Valid/ready initiator to TCDM req/gnt bridge with credit-limited in-order response FIFO.
// Requests pass through combinationally; responses appear one cycle after vld_i, held under rsp_ready_i=0.
module tcdm_master_shim #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteRespOn    = 1'b1,
  parameter int unsigned RespLat        = 2,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1),
  localparam int unsigned PtrWidth      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int unsigned SupWidth      = $clog2(RespLat + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic                 in_wen_i,
  input  logic [DataWidth-1:0] in_wdata_i,
  input  logic [BeWidth-1:0]   in_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic                 vld_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic [CntWidth-1:0]  outstanding_o
);

  logic [CntWidth-1:0]  cnt_q, cnt_d, occ_q, occ_d;
  logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SupWidth-1:0]  sup_q;
  logic [DataWidth-1:0] mem_q [MaxOutstanding];
  logic                 credit_ok, xfer, inc, push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign credit_ok     = cnt_q < CntWidth'(MaxOutstanding);
  assign req_o         = in_valid_i & credit_ok;
  assign in_ready_o    = gnt_i & credit_ok;
  assign add_o         = in_addr_i;
  assign wen_o         = in_wen_i;
  assign wdata_o       = in_wdata_i;
  assign be_o          = in_be_i;
  assign outstanding_o = cnt_q;

  assign xfer = req_o & gnt_i;
  assign inc  = xfer & (~in_wen_i | WriteRespOn);

  // A response is only legal while some granted transaction still lacks one.
  assign push        = vld_i & (occ_q != cnt_q);
  assign rsp_valid_o = (occ_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = mem_q[rptr_q];

  always_comb begin
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    case ({inc, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({push, pop})
      2'b10:   occ_d = occ_q + CntWidth'(1);
      2'b01:   occ_d = occ_q - CntWidth'(1);
      default: occ_d = occ_q;
    endcase
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rdata_i;
  end

  // Responses to requests in flight across reset may still land for a few cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sup_q <= SupWidth'(RespLat);
    end else if (sup_q != '0) begin
      sup_q <= sup_q - SupWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && (sup_q == '0)) begin
      unexpected_rsp: assert (!(vld_i && (occ_q == cnt_q)));
    end
  end

endmodule

// File: tb/tb_tcdm_master_shim.sv
// Bench for tcdm_master_shim: two instances (4 credits with store responses, 3 credits without),
// a transaction-level interconnect/reference model, and a scoreboard monitor for responses and outputs.
module tb_tcdm_master_shim;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_wen, gnt, rsp_ready, stray;
  logic [31:0] in_addr, in_wdata, tx_data;
  logic [3:0]  in_be;
  logic        vld [2] = '{1'b0, 1'b0};
  logic [31:0] rdata [2];
  int          rsp_prob;

  logic        req_a, rdy_a, rv_a, wen_a, req_b, rdy_b, rv_b, wen_b;
  logic [31:0] rd_a, add_a, wd_a, rd_b, add_b, wd_b;
  logic [3:0]  be_a, be_b;
  logic [2:0]  outst_a;
  logic [1:0]  outst_b;

  tcdm_master_shim #(.MaxOutstanding(4), .WriteRespOn(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_a), .in_addr_i(in_addr), .in_wen_i(in_wen),
    .in_wdata_i(in_wdata), .in_be_i(in_be),
    .rsp_valid_o(rv_a), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd_a),
    .req_o(req_a), .gnt_i(gnt), .add_o(add_a), .wen_o(wen_a), .wdata_o(wd_a), .be_o(be_a),
    .vld_i(vld[0]), .rdata_i(rdata[0]), .outstanding_o(outst_a));

  tcdm_master_shim #(.MaxOutstanding(3), .WriteRespOn(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_b), .in_addr_i(in_addr), .in_wen_i(in_wen),
    .in_wdata_i(in_wdata), .in_be_i(in_be),
    .rsp_valid_o(rv_b), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd_b),
    .req_o(req_b), .gnt_i(gnt), .add_o(add_b), .wen_o(wen_b), .wdata_o(wd_b), .be_o(be_b),
    .vld_i(vld[1]), .rdata_i(rdata[1]), .outstanding_o(outst_b));

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int maxo(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  // Reference model: credits in use, visible responses, pending interconnect replies, expected data.
  int          m_cnt [2], m_occ [2], pt [2], ph [2], et [2], eh [2];
  int          rsp_count [2], grant_count [2];
  int          peak_b;
  logic [31:0] pend [2][64];
  logic [31:0] expd [2][64];
  bit          mx, mw, mp, mu;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_occ[k] = 0; pt[k] = 0; et[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mx = in_valid && gnt && (m_cnt[k] < maxo(k));
        mw = mx && (!in_wen || k == 0);
        mp = rsp_ready && (m_occ[k] > 0);
        mu = vld[k] && (m_occ[k] != m_cnt[k]);
        if (mw) begin
          pend[k][pt[k] % 64] = tx_data + 32'(k);
          expd[k][et[k] % 64] = tx_data + 32'(k);
          pt[k]++;
          et[k]++;
        end
        m_cnt[k] += int'(mw) - int'(mp);
        m_occ[k] += int'(mu) - int'(mp);
      end
    end
  end

  // Interconnect: replies in order with random delay; 'stray' injects responses nobody asked for.
  always @(posedge clk_i) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (stray) begin
        vld[k] = 1'b1;
        rdata[k] = $urandom;
        if (!rst_n) ph[k] = 0;
      end else if (!rst_n) begin
        vld[k] = 1'b0;
        ph[k] = 0;
      end else if (ph[k] != pt[k] && $urandom_range(99) < rsp_prob) begin
        vld[k] = 1'b1;
        rdata[k] = pend[k][ph[k] % 64];
        ph[k]++;
      end else begin
        vld[k] = 1'b0;
      end
    end
  end

  task automatic mon(input int k, input logic rq, input logic rd, input logic rv,
                     input logic [31:0] rdat, input int oc);
    chk($sformatf("outstanding%0d", k), oc, m_cnt[k]);
    chk($sformatf("req%0d", k), rq, in_valid && (m_cnt[k] < maxo(k)));
    chk($sformatf("in_ready%0d", k), rd, gnt && (m_cnt[k] < maxo(k)));
    chk($sformatf("rsp_valid%0d", k), rv, m_occ[k] > 0);
    if (rv && rsp_ready) begin
      rsp_count[k]++;
      if (eh[k] == et[k]) begin
        total++;
        bad++;
        $display("FAIL rsp_extra%0d: got response %0h expected none", k, rdat);
      end else begin
        chk($sformatf("rsp_data%0d", k), rdat, expd[k][eh[k] % 64]);
        eh[k]++;
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_n) begin
      eh[0] = 0;
      eh[1] = 0;
    end else begin
      mon(0, req_a, rdy_a, rv_a, rd_a, int'(outst_a));
      mon(1, req_b, rdy_b, rv_b, rd_b, int'(outst_b));
      chk("pass_a", {add_a, wen_a, wd_a, be_a}, {in_addr, in_wen, in_wdata, in_be});
      chk("pass_b", {add_b, wen_b, wd_b, be_b}, {in_addr, in_wen, in_wdata, in_be});
      grant_count[0] += int'(req_a && gnt);
      grant_count[1] += int'(req_b && gnt);
      if (int'(outst_b) > peak_b) peak_b = int'(outst_b);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic drain();
    in_valid = 1'b0; rsp_ready = 1'b1; rsp_prob = 100;
    for (int i = 0; i < 200 && (m_cnt[0] != 0 || m_cnt[1] != 0); i++) cyc(1);
    cyc(1);
    chk("drain_outst_a", outst_a, 0);
    chk("drain_outst_b", outst_b, 0);
  endtask

  task automatic rand_phase(input int n, input int ready_pct);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_wen    = 1'($urandom);
      in_addr   = $urandom;
      in_wdata  = $urandom;
      in_be     = 4'($urandom);
      gnt       = ($urandom_range(3) != 0);
      rsp_ready = ($urandom_range(99) < ready_pct);
      tx_data   = $urandom;
      rsp_prob  = 70;
      cyc(1);
    end
  endtask

  int g0, r0, r1;

  initial begin
    in_valid = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0; in_be = 4'hf;
    gnt = 1'b1; rsp_ready = 1'b1; tx_data = '0; rsp_prob = 100; stray = 1'b0; peak_b = 0;
    #3;
    in_valid = 1'b1;
    #1;
    chk("rst_req_a", req_a, 1);
    chk("rst_req_b", req_b, 1);
    chk("rst_rv_a", rv_a, 0);
    chk("rst_outst_a", outst_a, 0);
    in_valid = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // Single load
    in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h100; tx_data = 32'hDEADBEEF; r0 = rsp_count[0];
    cyc(1);
    in_valid = 1'b0;
    chk("load_cnt1", outst_a, 1);
    cyc(1);
    chk("load_rv", rv_a, 1);
    chk("load_data", rd_a, 32'hDEADBEEF);
    cyc(1);
    chk("load_cnt0", outst_a, 0);
    chk("load_rsp_n", rsp_count[0] - r0, 1);

    // Credit exhaustion and refill after one pop
    drain();
    rsp_ready = 1'b0; in_valid = 1'b1; in_wen = 1'b0; gnt = 1'b1; g0 = grant_count[0];
    cyc(6);
    chk("full_grants", grant_count[0] - g0, 4);
    chk("full_req", req_a, 0);
    chk("full_outst", outst_a, 4);
    rsp_ready = 1'b1;
    cyc(1);
    rsp_ready = 1'b0;
    chk("refill_req", req_a, 1);
    cyc(1);
    chk("refill_grants", grant_count[0] - g0, 5);
    chk("refill_outst", outst_a, 4);
    drain();

    // Grant withheld
    in_valid = 1'b1; gnt = 1'b0; g0 = grant_count[0]; r0 = rsp_count[0];
    cyc(3);
    chk("nognt_ready", rdy_a, 0);
    chk("nognt_grants", grant_count[0] - g0, 0);
    chk("nognt_rsp", rsp_count[0] - r0, 0);
    chk("nognt_outst", outst_a, 0);

    // Stores without responses on instance b
    gnt = 1'b1; rsp_ready = 1'b1; rsp_prob = 100; peak_b = 0;
    r0 = rsp_count[0]; r1 = rsp_count[1];
    in_valid = 1'b1; in_wen = 1'b1;
    cyc(3);
    in_wen = 1'b0;
    cyc(1);
    in_valid = 1'b0;
    cyc(6);
    chk("wr_peak_b", peak_b, 1);
    chk("wr_rsp_b", rsp_count[1] - r1, 1);
    chk("wr_rsp_a", rsp_count[0] - r0, 4);

    rand_phase(800, 70);
    rand_phase(400, 20);
    drain();

    // Reset with three transactions in flight
    rsp_prob = 0; rsp_ready = 1'b0; in_valid = 1'b1; in_wen = 1'b0; gnt = 1'b1;
    cyc(3);
    chk("pre_rst_outst_a", outst_a, 3);
    chk("pre_rst_req_b", req_b, 0);
    stray = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_outst_a", outst_a, 0);
    chk("arst_outst_b", outst_b, 0);
    chk("arst_rv_a", rv_a, 0);
    chk("arst_req_b", req_b, 1);
    in_valid = 1'b0; rsp_ready = 1'b1;
    r0 = rsp_count[0]; r1 = rsp_count[1];
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    stray = 1'b0;
    cyc(3);
    chk("post_rst_rv_a", rv_a, 0);
    chk("post_rst_outst_a", outst_a, 0);
    chk("post_rst_rsp", (rsp_count[0] - r0) + (rsp_count[1] - r1), 0);

    rand_phase(400, 60);
    drain();
    chk("sb_empty_a", et[0] - eh[0], 0);
    chk("sb_empty_b", et[1] - eh[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
